// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Two-master arbiter in front of a single-port on-chip RAM with a fixed read
// latency of one clock. Grant is combinational, so the granted master sees
// waitrequest low in the same cycle it requests.
//
// Configuration macro: ONCHIP_ARB_RR_EN
//   defined   -> round-robin on ties (the master that was not granted last wins)
//   undefined -> fixed priority on ties (master 0 always wins)
//
// Ports
//   clk, reset                     single clock, synchronous active-high reset
//   mN_address/byteenable/read/write/writedata   master N command (N = 0, 1)
//   mN_waitrequest                 high = master N command not accepted
//   mN_readdata/readdatavalid      master N read response, one cycle after accept
//   mem_address/byteenable/writedata/chipselect/write/clken   RAM port
//   mem_readdata                   RAM output, valid one clock after the address
module onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic              req0_s;
    logic              req1_s;
    logic              gnt_valid_s;
    logic              gnt_idx_s;
    logic              rd_accept_s;
    logic              rd_pending_r;
    logic              rd_owner_r;
    logic              last_grant_r;
    logic [DATA_W-1:0] rd0_hold_r;
    logic [DATA_W-1:0] rd1_hold_r;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Grant selection: at most one master per cycle, nothing while in reset.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = 1'b0;
        if (reset) begin
            gnt_valid_s = 1'b0;
            gnt_idx_s   = 1'b0;
        end else if (req0_s && req1_s) begin
            gnt_valid_s = 1'b1;
`ifdef ONCHIP_ARB_RR_EN
            // Tie goes to the master that did not win the last transfer.
            gnt_idx_s   = ~last_grant_r;
`else
            // Fixed priority: last_grant is still tracked but never steers a tie.
            gnt_idx_s   = last_grant_r & 1'b0;
`endif
        end else if (req0_s) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = 1'b0;
        end else if (req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_idx_s   = 1'b0;
        end
    end

    // RAM command mux; with no grant the master 0 buses pass through as don't-care.
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        if (gnt_valid_s && gnt_idx_s) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (gnt_valid_s) begin
            mem_write      = m0_write;
        end else begin
            mem_write      = 1'b0;
        end
    end

    assign mem_chipselect = gnt_valid_s;
    assign mem_clken      = ~reset;
    assign m0_waitrequest = ~(gnt_valid_s & ~gnt_idx_s);
    assign m1_waitrequest = ~(gnt_valid_s & gnt_idx_s);

    // Read+write together is a write, so only a pure read earns a response.
    assign rd_accept_s = gnt_valid_s & ~mem_write;

    // Response tracking and arbitration history.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_r <= 1'b0;
            rd_owner_r   <= 1'b0;
            last_grant_r <= 1'b1;
            rd0_hold_r   <= '0;
            rd1_hold_r   <= '0;
        end else begin
            rd_pending_r <= rd_accept_s;
            rd_owner_r   <= gnt_idx_s;
            if (gnt_valid_s) begin
                last_grant_r <= gnt_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            // Capture the delivered word so a master's readdata holds afterwards.
            if (rd_pending_r && !rd_owner_r) begin
                rd0_hold_r <= mem_readdata;
            end else begin
                rd0_hold_r <= rd0_hold_r;
            end
            if (rd_pending_r && rd_owner_r) begin
                rd1_hold_r <= mem_readdata;
            end else begin
                rd1_hold_r <= rd1_hold_r;
            end
        end
    end

    // A read accepted just before reset would surface during reset; gating
    // with reset drops it.
    assign m0_readdatavalid = rd_pending_r & ~rd_owner_r & ~reset;
    assign m1_readdatavalid = rd_pending_r &  rd_owner_r & ~reset;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : rd0_hold_r;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : rd1_hold_r;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter with a behavioural 1024x32 RAM
// (registered address, unregistered output). Directed vector table plus hand
// sequences for reset-drop and tie arbitration in both build configurations.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;

    int total = 0;
    int bad   = 0;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model
    logic [31:0] ram [0:1023];
    logic [9:0]  ram_addr_r = 10'd0;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            ram_addr_r <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_r];

    typedef struct {
        logic        m0r, m0w; logic [9:0] m0a; logic [3:0] m0be; logic [31:0] m0wd;
        logic        m1r, m1w; logic [9:0] m1a; logic [3:0] m1be; logic [31:0] m1wd;
        logic        ew0, ew1, ecs, ewe;
        logic [9:0]  eaddr; logic [3:0] ebe; logic [31:0] ewd;
        logic        ev0; logic [31:0] erd0; logic ev1; logic [31:0] erd1;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic m0r, input logic m0w, input logic [9:0] m0a, input logic [3:0] m0be, input logic [31:0] m0wd,
        input logic m1r, input logic m1w, input logic [9:0] m1a, input logic [3:0] m1be, input logic [31:0] m1wd,
        input logic ew0, input logic ew1, input logic ecs, input logic ewe,
        input logic [9:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
        input logic ev0, input logic [31:0] erd0, input logic ev1, input logic [31:0] erd1);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0be = m0be; v.m0wd = m0wd;
        v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1be = m1be; v.m1wd = m1wd;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe;
        v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd;
        v.ev0 = ev0; v.erd0 = erd0; v.ev1 = ev1; v.erd1 = erd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = 10'd0; m0_byteenable = 4'd0; m0_writedata = 32'd0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = 10'd0; m1_byteenable = 4'd0; m1_writedata = 32'd0;
    endtask

    initial begin
        int g;
        int prev_g;
        string tag;

        //                m0: r     w     addr     be    wdata          m1: r     w     addr     be    wdata
        //                exp: w0   w1    cs    we    addr     be    wdata          v0    rd0            v1    rd1
        vecs[0]  = mk(1'b0,1'b1,10'h005,4'hF,32'hDEADBEEF, 1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b1,10'h005,4'hF,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0);
        vecs[1]  = mk(1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,10'h005,4'h0,32'h0,
                      1'b1,1'b0,1'b1,1'b0,10'h005,4'h0,32'h0,        1'b0,32'h0,        1'b0,32'h0);
        vecs[2]  = mk(1'b0,1'b1,10'h3FF,4'hF,32'hFFFFFFFF, 1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b1,10'h3FF,4'hF,32'hFFFFFFFF, 1'b0,32'h0,        1'b1,32'hDEADBEEF);
        vecs[3]  = mk(1'b0,1'b1,10'h3FF,4'h3,32'h12345678, 1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b1,10'h3FF,4'h3,32'h12345678, 1'b0,32'h0,        1'b0,32'hDEADBEEF);
        vecs[4]  = mk(1'b1,1'b0,10'h3FF,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b0,10'h3FF,4'h0,32'h0,        1'b0,32'h0,        1'b0,32'hDEADBEEF);
        vecs[5]  = mk(1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,10'h3FF,4'h0,32'h0,
                      1'b1,1'b0,1'b1,1'b0,10'h3FF,4'h0,32'h0,        1'b1,32'hFFFF5678, 1'b0,32'hDEADBEEF);
        vecs[6]  = mk(1'b1,1'b0,10'h005,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b0,10'h005,4'h0,32'h0,        1'b0,32'hFFFF5678, 1'b1,32'hFFFF5678);
        vecs[7]  = mk(1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b1,1'b1,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'hFFFF5678);
        vecs[8]  = mk(1'b1,1'b1,10'h010,4'hF,32'h0A0B0C0D, 1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b0,1'b1,1'b1,1'b1,10'h010,4'hF,32'h0A0B0C0D, 1'b0,32'hDEADBEEF, 1'b0,32'hFFFF5678);
        vecs[9]  = mk(1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,10'h010,4'h0,32'h0,
                      1'b1,1'b0,1'b1,1'b0,10'h010,4'h0,32'h0,        1'b0,32'hDEADBEEF, 1'b0,32'hFFFF5678);
        vecs[10] = mk(1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,
                      1'b1,1'b1,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,32'hDEADBEEF, 1'b1,32'h0A0B0C0D);

        // Reset for 3 cycles with requests present: nothing may be granted.
        reset = 1'b1;
        idle_inputs();
        m0_read = 1'b1; m1_write = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_w0",  {31'd0, m0_waitrequest}, 32'd1);
        chk("rst_w1",  {31'd0, m1_waitrequest}, 32'd1);
        chk("rst_cs",  {31'd0, mem_chipselect}, 32'd0);
        chk("rst_we",  {31'd0, mem_write}, 32'd0);
        chk("rst_ck",  {31'd0, mem_clken}, 32'd0);
        chk("rst_v0",  {31'd0, m0_readdatavalid}, 32'd0);
        chk("rst_v1",  {31'd0, m1_readdatavalid}, 32'd0);
        chk("rst_rd0", m0_readdata, 32'd0);
        chk("rst_rd1", m1_readdata, 32'd0);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            m0_read = vecs[i].m0r; m0_write = vecs[i].m0w; m0_address = vecs[i].m0a;
            m0_byteenable = vecs[i].m0be; m0_writedata = vecs[i].m0wd;
            m1_read = vecs[i].m1r; m1_write = vecs[i].m1w; m1_address = vecs[i].m1a;
            m1_byteenable = vecs[i].m1be; m1_writedata = vecs[i].m1wd;
            @(negedge clk);
            tag = $sformatf("v%0d", i);
            chk({tag, "_w0"},  {31'd0, m0_waitrequest}, {31'd0, vecs[i].ew0});
            chk({tag, "_w1"},  {31'd0, m1_waitrequest}, {31'd0, vecs[i].ew1});
            chk({tag, "_cs"},  {31'd0, mem_chipselect}, {31'd0, vecs[i].ecs});
            chk({tag, "_we"},  {31'd0, mem_write}, {31'd0, vecs[i].ewe});
            chk({tag, "_ck"},  {31'd0, mem_clken}, 32'd1);
            chk({tag, "_adr"}, {22'd0, mem_address}, {22'd0, vecs[i].eaddr});
            chk({tag, "_be"},  {28'd0, mem_byteenable}, {28'd0, vecs[i].ebe});
            chk({tag, "_wd"},  mem_writedata, vecs[i].ewd);
            chk({tag, "_v0"},  {31'd0, m0_readdatavalid}, {31'd0, vecs[i].ev0});
            chk({tag, "_v1"},  {31'd0, m1_readdatavalid}, {31'd0, vecs[i].ev1});
            chk({tag, "_rd0"}, m0_readdata, vecs[i].erd0);
            chk({tag, "_rd1"}, m1_readdata, vecs[i].erd1);
        end

        // Read accepted, then reset next cycle: response must be dropped.
        @(posedge clk); #1;
        idle_inputs();
        m0_read = 1'b1; m0_address = 10'h005;
        @(negedge clk);
        chk("rd_before_rst_w0", {31'd0, m0_waitrequest}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("drop_v0", {31'd0, m0_readdatavalid}, 32'd0);
        chk("drop_w0", {31'd0, m0_waitrequest}, 32'd1);
        chk("drop_w1", {31'd0, m1_waitrequest}, 32'd1);
        chk("drop_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("drop_ck", {31'd0, mem_clken}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("drop2_v0",  {31'd0, m0_readdatavalid}, 32'd0);
        chk("drop2_rd0", m0_readdata, 32'd0);

        // Both masters read continuously; first cycle after reset.
        prev_g = -1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            m0_read = (k < 6); m0_address = 10'h005;
            m1_read = (k < 7); m1_address = 10'h3FF;
            @(negedge clk);
            if (k < 6) begin
`ifdef ONCHIP_ARB_RR_EN
                g = k % 2;
`else
                g = 0;
`endif
            end else if (k == 6) begin
                g = 1;
            end else begin
                g = -1;
            end
            tag = $sformatf("tie%0d", k);
            chk({tag, "_w0"}, {31'd0, m0_waitrequest}, (g == 0) ? 32'd0 : 32'd1);
            chk({tag, "_w1"}, {31'd0, m1_waitrequest}, (g == 1) ? 32'd0 : 32'd1);
            chk({tag, "_cs"}, {31'd0, mem_chipselect}, (g >= 0) ? 32'd1 : 32'd0);
            chk({tag, "_v0"}, {31'd0, m0_readdatavalid}, (prev_g == 0) ? 32'd1 : 32'd0);
            chk({tag, "_v1"}, {31'd0, m1_readdatavalid}, (prev_g == 1) ? 32'd1 : 32'd0);
            if (prev_g == 0) chk({tag, "_rd0"}, m0_readdata, 32'hDEADBEEF);
            if (prev_g == 1) chk({tag, "_rd1"}, m1_readdata, 32'hFFFF5678);
            prev_g = g;
        end

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("end_v0", {31'd0, m0_readdatavalid}, 32'd0);
        chk("end_v1", {31'd0, m1_readdatavalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
